// File: rtl/mem_port_arbiter.sv
// Two-port round-robin front end for a single-port synchronous RAM.
// Each access is latched at grant and sequenced IDLE -> ACCESS -> (WAIT) -> DONE.
module mem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: reqN rises with weN/addrN/wdataN stable and stays high until ackN;
  // ackN is a one-cycle completion pulse, and the requester drops reqN by the edge
  // that ends that pulse (a req still high back in IDLE counts as a new request).
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_grant_q, last_grant_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic                pick;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    pick         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes first.
          pick         = (req0 && req1) ? ~last_grant_q : req1;
          gnt_d        = pick;
          last_grant_d = pick;
          ram_en_d     = 1'b1;
          ram_we_d     = pick ? we1 : we0;
          ram_addr_d   = pick ? addr1 : addr0;
          ram_wdata_d  = pick ? wdata1 : wdata0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (ram_we_q) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d   = 3'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'(RD_LAT)) begin
          if (gnt_q) rdata1_d = ram_rdata;
          else       rdata0_d = ram_rdata;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (read latency 1, 3, 4), each with its own RAM
// and a transaction-timeline reference model checked every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic [2:0] rst;

  logic [2:0][1:0]       req;
  logic [2:0][1:0]       we_v;
  logic [2:0][1:0][8:0]  addr_v;
  logic [2:0][1:0][31:0] wdata_v;

  logic [2:0]       ack0_w, ack1_w, busy_w, en_w, we_w;
  logic [2:0][31:0] rd0_w, rd1_w, rwdata_w, ram_rdata_w;
  logic [2:0][8:0]  raddr_w;
  logic [2:0][1:0]  st_w;

  logic [31:0] ram_mem [3][512];
  logic [31:0] pipe    [3][4];
  int          wr_cnt  [3];

  int errors = 0;
  int checks = 0;
  int order_q[$];
  int lat_tab[3] = '{1, 3, 4};

  // Reference model: an access is a timeline of m_len busy cycles after the grant edge.
  bit [2:0]         m_valid = '0;
  bit [2:0]         m_act   = '0;
  int               m_k    [3];
  int               m_len  [3];
  int               m_port [3];
  int               m_last [3];
  bit [2:0]         m_we;
  logic [2:0][8:0]  m_addr;
  logic [2:0][31:0] e_wdata;
  logic [2:0][1:0][31:0] e_rd;
  logic [31:0]      m_mem [3][512];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .RD_LAT(L)) u_dut (
      .clk(clk), .rst(rst[g]),
      .req0(req[g][0]), .req1(req[g][1]), .we0(we_v[g][0]), .we1(we_v[g][1]),
      .addr0(addr_v[g][0]), .addr1(addr_v[g][1]),
      .wdata0(wdata_v[g][0]), .wdata1(wdata_v[g][1]),
      .ack0(ack0_w[g]), .ack1(ack1_w[g]), .rdata0(rd0_w[g]), .rdata1(rd1_w[g]),
      .busy(busy_w[g]), .ram_en(en_w[g]), .ram_we(we_w[g]),
      .ram_addr(raddr_w[g]), .ram_wdata(rwdata_w[g]), .ram_rdata(ram_rdata_w[g]),
      .state_dbg(st_w[g])
    );
    assign ram_rdata_w[g] = pipe[g][L-1];
  end

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A5A0000 | a;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      wr_cnt[i] = 0;
      for (int s = 0; s < 4; s++) pipe[i][s] = 32'hBAD0_0000;
      for (int a = 0; a < 512; a++) begin
        ram_mem[i][a] = init_word(a);
        m_mem[i][a]   = init_word(a);
      end
    end
  end

  // RAM environment: write on the sampled enable, read data appears RD_LAT cycles later.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (en_w[i] && we_w[i]) begin
        ram_mem[i][raddr_w[i]] <= rwdata_w[i];
        wr_cnt[i] <= wr_cnt[i] + 1;
      end
      for (int s = 3; s > 0; s--) pipe[i][s] <= pipe[i][s-1];
      pipe[i][0] <= en_w[i] ? ram_mem[i][raddr_w[i]] : 32'hBAD0_0000;
    end
  end

  always @(posedge clk) begin : model
    int p;
    for (int i = 0; i < 3; i++) begin
      p = 0;
      if (rst[i]) begin
        m_valid[i] <= 1'b1;
        m_act[i]   <= 1'b0;
        m_last[i]  <= 1;
        m_k[i]     <= 0;
        m_len[i]   <= 0;
        m_port[i]  <= 0;
        m_we[i]    <= 1'b0;
        m_addr[i]  <= '0;
        e_wdata[i] <= '0;
        e_rd[i]    <= '0;
      end else if (m_act[i]) begin
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] + 1 > m_len[i]) m_act[i] <= 1'b0;
        else if (m_k[i] + 1 == m_len[i] && !m_we[i]) e_rd[i][m_port[i]] <= m_mem[i][m_addr[i]];
      end else if (req[i] != 2'b00) begin
        if (req[i] == 2'b11) p = 1 - m_last[i];
        else                 p = req[i][1] ? 1 : 0;
        m_last[i]  <= p;
        m_port[i]  <= p;
        m_we[i]    <= we_v[i][p];
        m_addr[i]  <= addr_v[i][p];
        e_wdata[i] <= wdata_v[i][p];
        m_len[i]   <= we_v[i][p] ? 2 : 2 + lat_tab[i];
        m_k[i]     <= 1;
        m_act[i]   <= 1'b1;
        if (we_v[i][p]) m_mem[i][addr_v[i][p]] <= wdata_v[i][p];
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h exp=%h at %0t", nm, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i]) begin
        chk("busy",      i, 32'(busy_w[i]), 32'(m_act[i]));
        chk("ram_en",    i, 32'(en_w[i]),   32'(m_act[i] && m_k[i] == 1));
        chk("ram_we",    i, 32'(we_w[i]),   32'(m_act[i] && m_k[i] == 1 && m_we[i]));
        chk("ram_addr",  i, 32'(raddr_w[i]), 32'(m_addr[i]));
        chk("ram_wdata", i, rwdata_w[i],    e_wdata[i]);
        chk("ack0",      i, 32'(ack0_w[i]), 32'(m_act[i] && m_k[i] == m_len[i] && m_port[i] == 0));
        chk("ack1",      i, 32'(ack1_w[i]), 32'(m_act[i] && m_k[i] == m_len[i] && m_port[i] == 1));
        chk("rdata0",    i, rd0_w[i],       e_rd[i][0]);
        chk("rdata1",    i, rd1_w[i],       e_rd[i][1]);
      end
    end
  end

  // Raise a request, hold it until its ack is seen, drop it inside the ack cycle.
  task automatic do_access(input int i, input int p, input logic w, input logic [8:0] a,
                           input logic [31:0] d, output int edges, output logic [31:0] rd);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    rd    = '0;
    @(negedge clk);
    we_v[i][p]    = w;
    addr_v[i][p]  = a;
    wdata_v[i][p] = d;
    req[i][p]     = 1'b1;
    while (!seen && edges < 60) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = (p == 1) ? ack1_w[i] : ack0_w[i];
    end
    if (seen) begin
      rd = (p == 1) ? rd1_w[i] : rd0_w[i];
      order_q.push_back(p);
    end else begin
      checks++;
      errors++;
      $display("FAIL ack_timeout inst=%0d port=%0d got=none exp=ack", i, p);
    end
    req[i][p] = 1'b0;
  endtask

  initial begin
    int e1, e2, wc, n;
    logic [31:0] r1, r2;
    int ord_exp[4] = '{0, 1, 0, 1};
    rst = 3'b111;
    req = '0; we_v = '0; addr_v = '0; wdata_v = '0;
    repeat (2) @(negedge clk);
    rst = 3'b000;

    chk("rst_busy",   0, 32'(busy_w[0]), 32'd0);
    chk("rst_ram_en", 0, 32'(en_w[0]),   32'd0);
    chk("rst_state",  0, 32'(st_w[0]),   32'd0);

    // 1: CPU write, then 2: read it back (latency 1)
    do_access(0, 0, 1'b1, 9'h05, 32'hDEADBEEF, e1, r1);
    chk("t1_wr_edges", 0, e1, 32'd2);
    chk("t1_wr_count", 0, wr_cnt[0], 32'd1);
    chk("t1_ram_word", 0, ram_mem[0][5], 32'hDEADBEEF);
    do_access(0, 0, 1'b0, 9'h05, 32'h0, e1, r1);
    chk("t2_rd_edges", 0, e1, 32'd3);
    chk("t2_rdata0",   0, r1, 32'hDEADBEEF);
    chk("t2_rdata1",   0, rd1_w[0], 32'h0);

    // 3: tie right after reset, both held continuously -> 0,1,0,1
    @(negedge clk); rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    we_v[0] = 2'b00; addr_v[0][0] = 9'h001; addr_v[0][1] = 9'h002;
    req[0] = 2'b11;
    order_q.delete();
    n = 0;
    while (order_q.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (ack0_w[0]) order_q.push_back(0);
      if (ack1_w[0]) order_q.push_back(1);
    end
    req[0] = 2'b00;
    chk("t3_count", 0, order_q.size(), 32'd4);
    for (int k = 0; k < 4 && k < order_q.size(); k++) chk("t3_order", 0, order_q[k], ord_exp[k]);
    chk("t3_rdata0", 0, rd0_w[0], 32'h5A5A0001);
    chk("t3_rdata1", 0, rd1_w[0], 32'h5A5A0002);

    // 4: loader write raised while the CPU read is in WAIT
    @(negedge clk);
    order_q.delete();
    wc = wr_cnt[0];
    fork
      do_access(0, 0, 1'b0, 9'h07, 32'h0, e1, r1);
      begin
        repeat (2) @(negedge clk);
        do_access(0, 1, 1'b1, 9'h1A, 32'h12345678, e2, r2);
      end
    join
    chk("t4_first",  0, order_q.size() > 0 ? order_q[0] : -1, 32'd0);
    chk("t4_second", 0, order_q.size() > 1 ? order_q[1] : -1, 32'd1);
    chk("t4_rdata0", 0, r1, 32'h5A5A0007);
    chk("t4_writes", 0, wr_cnt[0] - wc, 32'd1);
    chk("t4_word",   0, ram_mem[0][9'h1A], 32'h12345678);

    // 5: latency-3 instance, reset while waiting at cnt=2
    do_access(1, 0, 1'b0, 9'h03, 32'h0, e1, r1);
    chk("t5_rd_edges", 1, e1, 32'd5);
    chk("t5_rdata0",   1, r1, 32'h5A5A0003);
    @(negedge clk);
    we_v[1][0] = 1'b0; addr_v[1][0] = 9'h004; req[1][0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_pre", 1, 32'(busy_w[1]), 32'd1);
    rst[1] = 1'b1; req[1][0] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("t5_ram_en", 1, 32'(en_w[1]),  32'd0);
    chk("t5_ack0",   1, 32'(ack0_w[1]), 32'd0);
    chk("t5_busy",   1, 32'(busy_w[1]), 32'd0);
    chk("t5_rdata0_clr", 1, rd0_w[1], 32'h0);
    order_q.delete();
    fork
      do_access(1, 0, 1'b0, 9'h001, 32'h0, e1, r1);
      do_access(1, 1, 1'b0, 9'h002, 32'h0, e2, r2);
    join
    chk("t5_tie_first", 1, order_q.size() > 0 ? order_q[0] : -1, 32'd0);
    chk("t5_tie_rd1",   1, r2, 32'h5A5A0002);

    // 6: latency-4 instance, write then read back
    do_access(2, 0, 1'b1, 9'h033, 32'hCAFEF00D, e1, r1);
    chk("t6_wr_edges", 2, e1, 32'd2);
    do_access(2, 1, 1'b0, 9'h033, 32'h0, e2, r2);
    chk("t6_rd_edges", 2, e2, 32'd6);
    chk("t6_rdata1",   2, r2, 32'hCAFEF00D);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
